// File: rtl/hs_stream_sink.sv
// Purpose: handshake stream consumer; buffers words, drains on a stall pattern, checks an incrementing sequence.
// Latency: accept-to-pop >= 1 cycle (no fall-through); err_o/counters update one cycle after the pop.
// Backpressure: rdy_to_send only in RUN and when not full (or full with a pop); HS_SINK_DUP_DETECT_EN enables repeat counting.
module hs_stream_sink #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int START = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     rdy_to_send,
    input  logic                     chk_en,
    input  logic [7:0]               stall_mask,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [WIDTH-1:0]         last_data,
    output logic [CNT_W-1:0]         rx_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         dup_cnt,
    output logic                     err_o,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [2:0]       phase;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] rd_word;
    logic             empty, full, push, pop;
    logic             is_match, is_dup;

    assign empty   = (fifo_level == '0);
    assign full    = (fifo_level == LW'(DEPTH));
    assign rd_word = mem[rd_ptr];
    assign busy    = (state != IDLE);

    // Reset gates the handshake so a word offered during reset is never seen as transferred.
    assign pop         = !rst && !empty && (state != IDLE) && !stall_mask[phase];
    assign rdy_to_send = !rst && (state == RUN) && (!full || pop);
    assign push        = en_i && rdy_to_send;

    assign is_match = (rd_word == expected);
`ifdef HS_SINK_DUP_DETECT_EN
    assign is_dup = !is_match && (rd_word == expected - WIDTH'(1));
`else
    assign is_dup = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (chk_en) state_nxt = RUN;
            RUN:     if (!chk_en) state_nxt = DRAIN;
            DRAIN: begin
                if (chk_en)
                    state_nxt = RUN;
                else if (empty && !pop)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            phase      <= '0;
            expected   <= WIDTH'(START);
            last_data  <= '0;
            rx_cnt     <= '0;
            err_cnt    <= '0;
            err_o      <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase + 3'd1;
            err_o <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: ;
            endcase
            if (pop) begin
                last_data <= rd_word;
                if (rx_cnt != '1)
                    rx_cnt <= rx_cnt + CNT_W'(1);
                if (is_match) begin
                    expected <= expected + WIDTH'(1);
                end else if (!is_dup) begin
                    // Resync so a single gap costs one error, not a cascade.
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + CNT_W'(1);
                    err_o    <= 1'b1;
                    expected <= rd_word + WIDTH'(1);
                end
            end
        end
    end

`ifdef HS_SINK_DUP_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst)
            dup_cnt <= '0;
        else if (pop && is_dup && dup_cnt != '1)
            dup_cnt <= dup_cnt + CNT_W'(1);
    end
`else
    assign dup_cnt = '0;
`endif

endmodule

// File: tb/tb_hs_stream_sink.sv
// Randomised and directed bench for hs_stream_sink against a transaction-level sequence model.
module tb_hs_stream_sink;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int START = 8;
    localparam int CNT_W = 5;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, en_i, chk_en, rdy_to_send, err_o, busy;
    logic [WIDTH-1:0] data_i, last_data;
    logic [7:0]       stall_mask;
    logic [LW-1:0]    fifo_level;
    logic [CNT_W-1:0] rx_cnt, err_cnt, dup_cnt;

    hs_stream_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .START(START), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .data_i(data_i), .rdy_to_send(rdy_to_send),
        .chk_en(chk_en), .stall_mask(stall_mask), .fifo_level(fifo_level),
        .last_data(last_data), .rx_cnt(rx_cnt), .err_cnt(err_cnt), .dup_cnt(dup_cnt),
        .err_o(err_o), .busy(busy)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] acc_q[$];
    logic [WIDTH-1:0] pop_q[$];
    int               err_pulses = 0;
    logic [CNT_W-1:0] prev_rx = '0;

    // Each rx_cnt step marks one pop; capture the drained word to check ordering.
    always @(negedge clk) begin
        if (rst) begin
            prev_rx = '0;
        end else begin
            if (rx_cnt != prev_rx)
                pop_q.push_back(last_data);
            prev_rx = rx_cnt;
            if (err_o)
                err_pulses++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; en_i = 1'b0; chk_en = 1'b0; stall_mask = 8'h00; data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        acc_q.delete();
        pop_q.delete();
        err_pulses = 0;
        rst = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] w, output int waited);
        bit ok = 0;
        bit acc;
        waited = 0;
        en_i = 1'b1;
        data_i = w;
        for (int c = 0; c < 64 && !ok; c++) begin
            if (c > 12) stall_mask = 8'h00;
            @(negedge clk);
            acc = rdy_to_send;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_q.push_back(w);
                ok = 1;
            end else begin
                waited++;
            end
        end
        en_i = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk("idle_reached", done, 1);
    endtask

    // Expected results from the sequence rules applied to the accepted words in order.
    task automatic check_model(input string tag);
        logic [WIDTH-1:0] exp_v = WIDTH'(START);
        int n = acc_q.size();
        int errs = 0, dups = 0, order_bad = 0, npop;
        foreach (acc_q[i]) begin
            if (acc_q[i] == exp_v) begin
                exp_v = exp_v + 1;
`ifdef HS_SINK_DUP_DETECT_EN
            end else if (acc_q[i] == exp_v - 1) begin
                dups++;
`endif
            end else begin
                errs++;
                exp_v = acc_q[i] + 1;
            end
        end
        npop = (n > SAT) ? SAT : n;
        chk({tag, ".rx"},     rx_cnt,  sat(n));
        chk({tag, ".err"},    err_cnt, sat(errs));
        chk({tag, ".dup"},    dup_cnt, sat(dups));
        chk({tag, ".pulses"}, err_pulses, errs);
        chk({tag, ".npop"},   pop_q.size(), npop);
        if (n > 0) chk({tag, ".last"}, last_data, acc_q[n-1]);
        for (int i = 0; i < pop_q.size() && i < n; i++)
            if (pop_q[i] != acc_q[i]) order_bad++;
        chk({tag, ".order"}, order_bad, 0);
        chk({tag, ".level"}, fifo_level, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w_cnt, stalls;
        logic [WIDTH-1:0] w;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst.rdy", rdy_to_send, 0);
        chk("rst.level", fifo_level, 0);
        chk("rst.last", last_data, 0);
        chk("rst.rx", rx_cnt, 0);
        chk("rst.err", err_cnt, 0);
        chk("rst.erro", err_o, 0);
        chk("rst.busy", busy, 0);

        // 1: back-to-back in-order stream
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            send(WIDTH'(START + i), w_cnt);
            stalls += w_cnt;
        end
        chk("t1.rdy_stall", stalls, 0);
        chk_en = 1'b0;
        wait_idle();
        chk("t1.rx", rx_cnt, 4);
        chk("t1.last", last_data, 11);
        check_model("t1");

        // 2: fill with stall-all, then drain
        do_reset();
        chk_en = 1'b1; stall_mask = 8'hFF;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(WIDTH'(START + i), w_cnt);
        en_i = 1'b1; data_i = 12;
        repeat (3) begin
            @(negedge clk);
            chk("t2.full_rdy", rdy_to_send, 0);
        end
        chk("t2.level", fifo_level, DEPTH);
        @(posedge clk); #1;
        stall_mask = 8'h00;
        send(12, w_cnt);
        chk_en = 1'b0;
        wait_idle();
        check_model("t2");

        // 3: gap then resync
        do_reset();
        chk_en = 1'b1;
        @(posedge clk); #1;
        send(8, w_cnt); send(9, w_cnt); send(33, w_cnt); send(34, w_cnt);
        chk_en = 1'b0;
        wait_idle();
        check_model("t3");

        // 4: repeated word
        do_reset();
        chk_en = 1'b1;
        @(posedge clk); #1;
        send(8, w_cnt); send(9, w_cnt); send(9, w_cnt); send(10, w_cnt);
        chk_en = 1'b0;
        wait_idle();
        check_model("t4");

        // 5: drain-out after run enable drops
        do_reset();
        chk_en = 1'b1; stall_mask = 8'hFF;
        @(posedge clk); #1;
        send(8, w_cnt); send(9, w_cnt); send(10, w_cnt);
        chk_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5.busy", busy, 1);
        chk("t5.rdy", rdy_to_send, 0);
        chk("t5.level", fifo_level, 3);
        @(posedge clk); #1;
        stall_mask = 8'h00;
        wait_idle();
        check_model("t5");

        // 6: reset mid-stream with a word offered in the reset cycle
        do_reset();
        chk_en = 1'b1; stall_mask = 8'hFF;
        @(posedge clk); #1;
        send(8, w_cnt); send(9, w_cnt); send(10, w_cnt);
        @(negedge clk);
        chk("t6.level_pre", fifo_level, 3);
        @(posedge clk); #1;
        rst = 1'b1; en_i = 1'b1; data_i = 8;
        @(negedge clk);
        chk("t6.rst_rdy", rdy_to_send, 0);
        @(posedge clk); #1;
        rst = 1'b0; en_i = 1'b0;
        acc_q.delete(); pop_q.delete(); err_pulses = 0;
        @(negedge clk);
        chk("t6.level", fifo_level, 0);
        chk("t6.rx", rx_cnt, 0);
        chk("t6.err", err_cnt, 0);
        chk("t6.busy", busy, 0);
        @(posedge clk); #1;
        stall_mask = 8'h00;
        @(posedge clk); #1;
        send(8, w_cnt); send(9, w_cnt);
        chk_en = 1'b0;
        wait_idle();
        check_model("t6");

        // Random: gaps, repeats, wrap, random stall masks, run-enable blips, saturation
        for (int r = 0; r < 3; r++) begin
            do_reset();
            chk_en = 1'b1;
            @(posedge clk); #1;
            w = WIDTH'(START) - 1;
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 9))
                    0:       w = $urandom;
                    1:       ;
                    2:       w = 32'hFFFF_FFFE;
                    default: w = w + 1;
                endcase
                stall_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                send(w, w_cnt);
                if ($urandom_range(0, 7) == 0) begin
                    chk_en = 1'b0;
                    @(posedge clk); #1;
                    chk_en = 1'b1;
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            chk_en = 1'b0;
            stall_mask = 8'h00;
            wait_idle();
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
